// File: rtl/apsr_cond_unit.sv
// APSR NZCV flag register, ARMv7-M condition evaluation and Thumb ITSTATE sequencing.
// cond_pass is combinational from the registered flags and the registered ITSTATE.
module apsr_cond_unit #(
  parameter logic [3:0] FLAGS_RST = 4'b0000,
  parameter bit         IT_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] flags_in,
  input  logic [3:0] flags_we,
  input  logic [3:0] cond,
  input  logic       it_load,
  input  logic [3:0] it_first,
  input  logic [3:0] it_mask,
  input  logic       retire,
  input  logic       it_clear,
  output logic [3:0] flags_q,
  output logic [3:0] eff_cond,
  output logic       cond_pass,
  output logic       in_it,
  output logic       it_last
);

  logic [7:0] itstate_r;
  logic [7:0] itstate_next_s;
  logic [3:0] flags_next_s;

  // ARMv7-M condition code against {N,Z,C,V}; codes E and F both mean always
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    logic r;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'h0:    r = z;
      4'h1:    r = ~z;
      4'h2:    r = cy;
      4'h3:    r = ~cy;
      4'h4:    r = n;
      4'h5:    r = ~n;
      4'h6:    r = v;
      4'h7:    r = ~v;
      4'h8:    r = cy & ~z;
      4'h9:    r = ~cy | z;
      4'hA:    r = (n == v);
      4'hB:    r = (n != v);
      4'hC:    r = ~z & (n == v);
      4'hD:    r = z | (n != v);
      default: r = 1'b1;
    endcase
    return r;
  endfunction

  assign in_it     = (itstate_r[3:0] != 4'b0000);
  assign it_last   = in_it && (itstate_r[2:0] == 3'b000);
  assign eff_cond  = in_it ? itstate_r[7:4] : cond;
  assign cond_pass = cond_eval(eff_cond, flags_q);

  // Per-bit masked flag capture
  always_comb begin
    flags_next_s = (flags_we & flags_in) | (~flags_we & flags_q);
  end

  // ITSTATE next-state: clear beats load beats advance; a zero mask is not a valid IT
  always_comb begin
    itstate_next_s = itstate_r;
    if (it_clear) begin
      itstate_next_s = 8'h00;
    end else if (it_load) begin
      if ((it_mask != 4'b0000) && IT_EN) begin
        itstate_next_s = {it_first, it_mask};
      end else begin
        itstate_next_s = itstate_r;
      end
    end else if (retire && in_it) begin
      if (it_last) begin
        itstate_next_s = 8'h00;
      end else begin
        itstate_next_s = {itstate_r[7:5], itstate_r[3:0], 1'b0};
      end
    end else begin
      itstate_next_s = itstate_r;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q   <= FLAGS_RST;
      itstate_r <= 8'h00;
    end else begin
      flags_q   <= flags_next_s;
      itstate_r <= IT_EN ? itstate_next_s : 8'h00;
    end
  end

endmodule

// File: tb/tb_apsr_cond_unit.sv
// Directed self-checking bench for apsr_cond_unit: reset, flag masking, full condition
// table, an ITTE EQ block, next-state priority and reset in the middle of an IT block.
module tb_apsr_cond_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] flags_in, flags_we, cond, it_first, it_mask;
  logic       it_load, retire, it_clear;
  logic [3:0] flags_q, eff_cond;
  logic       cond_pass, in_it, it_last;

  int tests  = 0;
  int failed = 0;

  apsr_cond_unit #(.FLAGS_RST(4'b0000), .IT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flags_in(flags_in), .flags_we(flags_we), .cond(cond),
    .it_load(it_load), .it_first(it_first), .it_mask(it_mask), .retire(retire),
    .it_clear(it_clear), .flags_q(flags_q), .eff_cond(eff_cond), .cond_pass(cond_pass),
    .in_it(in_it), .it_last(it_last)
  );

  always #5 clk = ~clk;

  // Reference: decode by cond[3:1] pair, then invert for odd codes (except 111x)
  function automatic logic ref_pass(input logic [3:0] c, input logic [3:0] f);
    logic base;
    case (c[3:1])
      3'd0: base = f[2];
      3'd1: base = f[1];
      3'd2: base = f[3];
      3'd3: base = f[0];
      3'd4: base = f[1] && !f[2];
      3'd5: base = (f[3] ~^ f[0]);
      3'd6: base = !f[2] && (f[3] ~^ f[0]);
      default: base = 1'b1;
    endcase
    if (c[0] && (c[3:1] != 3'd7)) return !base;
    return base;
  endfunction

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic write_flags(input logic [3:0] v);
    flags_in = v;
    flags_we = 4'b1111;
    step();
    flags_we = 4'b0000;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    step();
    rst  = 1'b0;
    cond = 4'h0;
    #1;
    chk4("reset_flags", flags_q, 4'b0000);
    chk1("reset_in_it", in_it, 1'b0);
    chk1("reset_it_last", it_last, 1'b0);
    chk4("reset_eff_cond", eff_cond, 4'h0);
    chk1("reset_eq_pass", cond_pass, 1'b0);
    cond = 4'h7;
    #1;
    chk4("reset_eff_cond_follows", eff_cond, 4'h7);
  endtask

  task automatic test_flags_mask;
    flags_in = 4'b1111;
    flags_we = 4'b0100;
    #1;
    chk4("mask_no_bypass", flags_q, 4'b0000);
    step();
    flags_we = 4'b0000;
    chk4("mask_z_only", flags_q, 4'b0100);
    cond = 4'h0; #1;
    chk1("mask_eq_pass", cond_pass, 1'b1);
    cond = 4'h2; #1;
    chk1("mask_cs_fail", cond_pass, 1'b0);
    flags_in = 4'b0000;
    flags_we = 4'b0010;
    step();
    flags_in = 4'b1111;
    flags_we = 4'b0010;
    step();
    flags_we = 4'b0000;
    chk4("mask_c_added", flags_q, 4'b0110);
    chk1("mask_cs_pass", cond_pass, 1'b1);
    flags_in = 4'b0000;
    flags_we = 4'b1000;
    step();
    flags_we = 4'b0000;
    chk4("mask_n_cleared_only", flags_q, 4'b0110);
  endtask

  task automatic test_cond_table;
    int bad = 0;
    for (int f = 0; f < 16; f++) begin
      write_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        cond = 4'(c);
        #1;
        tests++;
        if (cond_pass !== ref_pass(4'(c), 4'(f))) begin
          failed++;
          bad++;
          $display("FAIL cond_table nzcv=%b cond=%h: got %b expected %b",
                   4'(f), 4'(c), cond_pass, ref_pass(4'(c), 4'(f)));
        end
      end
    end
  endtask

  task automatic test_itte;
    write_flags(4'b0100);
    cond     = 4'hF;
    it_first = 4'b0000;
    it_mask  = 4'b0110;
    it_load  = 1'b1;
    step();
    it_load = 1'b0;
    chk1("itte_s1_in_it", in_it, 1'b1);
    chk4("itte_s1_eff", eff_cond, 4'h0);
    chk1("itte_s1_pass", cond_pass, 1'b1);
    chk1("itte_s1_last", it_last, 1'b0);
    retire   = 1'b1;
    flags_in = 4'b0110;
    flags_we = 4'b0010;
    step();
    flags_we = 4'b0000;
    chk4("itte_s2_eff", eff_cond, 4'h0);
    chk1("itte_s2_pass", cond_pass, 1'b1);
    chk1("itte_s2_last", it_last, 1'b0);
    chk4("itte_flags_with_retire", flags_q, 4'b0110);
    step();
    chk4("itte_s3_eff", eff_cond, 4'h1);
    chk1("itte_s3_pass", cond_pass, 1'b0);
    chk1("itte_s3_last", it_last, 1'b1);
    step();
    retire = 1'b0;
    chk1("itte_done_in_it", in_it, 1'b0);
    chk1("itte_done_last", it_last, 1'b0);
    chk4("itte_done_eff", eff_cond, 4'hF);
  endtask

  task automatic test_priority;
    cond     = 4'h3;
    it_first = 4'b0000;
    it_mask  = 4'b0001;
    it_load  = 1'b1;
    step();
    it_load = 1'b0;
    chk1("prio_loaded", in_it, 1'b1);
    retire   = 1'b1;
    it_clear = 1'b1;
    step();
    retire   = 1'b0;
    it_clear = 1'b0;
    chk1("prio_clear_beats_retire", in_it, 1'b0);
    chk4("prio_clear_eff", eff_cond, 4'h3);
    it_first = 4'b1010;
    it_mask  = 4'b0000;
    it_load  = 1'b1;
    step();
    it_load = 1'b0;
    chk1("prio_zero_mask_idle", in_it, 1'b0);
    retire = 1'b1;
    step();
    retire = 1'b0;
    chk1("prio_retire_idle", in_it, 1'b0);
    it_first = 4'b1100;
    it_mask  = 4'b1000;
    it_load  = 1'b1;
    step();
    chk4("prio_single_eff", eff_cond, 4'hC);
    chk1("prio_single_last", it_last, 1'b1);
    it_first = 4'b0011;
    it_mask  = 4'b0000;
    step();
    it_load = 1'b0;
    chk4("prio_zero_mask_hold_eff", eff_cond, 4'hC);
    chk1("prio_zero_mask_hold_last", it_last, 1'b1);
    retire = 1'b1;
    step();
    retire = 1'b0;
    chk1("prio_single_done", in_it, 1'b0);
  endtask

  task automatic test_reset_mid_block;
    write_flags(4'b1010);
    it_first = 4'b0000;
    it_mask  = 4'b0001;
    it_load  = 1'b1;
    step();
    it_load = 1'b0;
    retire  = 1'b1;
    step();
    retire = 1'b0;
    chk1("mid_still_in_it", in_it, 1'b1);
    chk1("mid_not_last", it_last, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk1("mid_rst_in_it", in_it, 1'b0);
    chk4("mid_rst_flags", flags_q, 4'b0000);
    chk4("mid_rst_eff", eff_cond, cond);
  endtask

  initial begin
    rst      = 1'b1;
    flags_in = 4'b0000;
    flags_we = 4'b0000;
    cond     = 4'h0;
    it_load  = 1'b0;
    it_first = 4'b0000;
    it_mask  = 4'b0000;
    retire   = 1'b0;
    it_clear = 1'b0;
    test_reset();
    test_flags_mask();
    test_cond_table();
    test_itte();
    test_priority();
    test_reset_mid_block();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
